// File: rtl/utu_dut_responder.sv
// DUT-side responder for the utu debug interface: a scratch RAM plus step/write/last-address CSRs,
// with registered read-back on tdin_o and a one-cycle step pulse derived from the debounced step level.
module utu_dut_responder #(
    parameter int unsigned AW       = 8,
    parameter logic [15:0] CSR_STEP = 16'hFFFF,
    parameter logic [15:0] CSR_WCNT = 16'hFFFE,
    parameter logic [15:0] CSR_LADR = 16'hFFFD,
    parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] taddr_i,
    input  logic [31:0] tdout_i,
    input  logic        twe_i,
    input  logic        step_stable_i,
    output logic [31:0] tdin_o,
    output logic        step_pulse_o,
    output logic        busy_o
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          busy_q;

    logic [31:0]   mem_q [DEPTH];

    logic          step_q;
    logic          step_pulse_q;
    logic [31:0]   step_cnt_q, step_cnt_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]   last_adr_q, last_adr_d;
    logic [31:0]   tdin_q, tdin_d;

    logic          in_ram;
    logic [AW-1:0] idx;
    logic          wr_ram;
    logic          wr_step;
    logic          edge_det;

    assign in_ram   = ((taddr_i >> AW) == 16'd0);
    assign idx      = taddr_i[AW-1:0];
    assign wr_ram   = (state_q == ST_IDLE) && twe_i && in_ram;
    assign wr_step  = (state_q == ST_IDLE) && twe_i && (taddr_i == CSR_STEP);
    assign edge_det = step_stable_i & ~step_q;

    // Sweep FSM: CLEAR runs exactly DEPTH cycles, IDLE is held until the next reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else if (state_q == ST_CLEAR) begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
            if (&clr_ptr_q) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_ram) begin
                mem_q[idx] <= tdout_i;
            end
        end
    end

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (wr_step) begin
            step_cnt_d = tdout_i;
        end else if (edge_det) begin
            step_cnt_d = step_cnt_q + 32'd1;
        end

        wr_cnt_d = wr_cnt_q;
        if (wr_ram || wr_step) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end

        last_adr_d = last_adr_q;
        if (wr_ram) begin
            last_adr_d = taddr_i;
        end
    end

    // Read mux; accepted writes bypass to the read port so tdin_o shows the new word.
    always_comb begin
        tdin_d = BAD_DATA;
        if (in_ram) begin
            tdin_d = mem_q[idx];
        end else if (taddr_i == CSR_STEP) begin
            tdin_d = step_cnt_q;
        end else if (taddr_i == CSR_WCNT) begin
            tdin_d = wr_cnt_q;
        end else if (taddr_i == CSR_LADR) begin
            tdin_d = {16'h0000, last_adr_q};
        end
        if (wr_ram || wr_step) begin
            tdin_d = tdout_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            step_cnt_q   <= '0;
            wr_cnt_q     <= '0;
            last_adr_q   <= '0;
            tdin_q       <= '0;
        end else begin
            step_q       <= step_stable_i;
            step_pulse_q <= edge_det;
            step_cnt_q   <= step_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            last_adr_q   <= last_adr_d;
            tdin_q       <= tdin_d;
        end
    end

    assign tdin_o       = tdin_q;
    assign step_pulse_o = step_pulse_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_utu_dut_responder.sv
// Directed bench for utu_dut_responder: sweep timing, RAM/CSR access, step pulses and reset restart.
module tb_utu_dut_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] taddr_i = '0;
    logic [31:0] tdout_i = '0;
    logic        twe_i = 1'b0;
    logic        step_stable_i = 1'b0;
    logic [31:0] tdin_o;
    logic        step_pulse_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int busy_len;

    localparam logic [15:0] A_STEP = 16'hFFFF;
    localparam logic [15:0] A_WCNT = 16'hFFFE;
    localparam logic [15:0] A_LADR = 16'hFFFD;
    localparam logic [31:0] BAD    = 32'hDEAD_BEEF;

    utu_dut_responder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .taddr_i       (taddr_i),
        .tdout_i       (tdout_i),
        .twe_i         (twe_i),
        .step_stable_i (step_stable_i),
        .tdin_o        (tdin_o),
        .step_pulse_o  (step_pulse_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        taddr_i = a;
        twe_i   = 1'b0;
        @(negedge clk_i);
        chk(tag, tdin_o, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp_bypass,
                      input string tag);
        taddr_i = a;
        tdout_i = d;
        twe_i   = 1'b1;
        @(negedge clk_i);
        twe_i   = 1'b0;
        chk(tag, tdin_o, exp_bypass);
    endtask

    task automatic step_edge(input string tag);
        step_stable_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_pulse_hi"}, {31'b0, step_pulse_o}, 32'd1);
        @(negedge clk_i);
        chk({tag, "_pulse_lo"}, {31'b0, step_pulse_o}, 32'd0);
        step_stable_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_pulse_idle"}, {31'b0, step_pulse_o}, 32'd0);
    endtask

    // Counts cycles busy_o stays high after reset release, optionally poking a write mid-sweep.
    task automatic measure_busy(input bit poke, output int len);
        len = 0;
        while (busy_o && len < 400) begin
            len++;
            if (poke && len == 10) begin
                taddr_i = 16'h0005;
                tdout_i = 32'hAAAA_5555;
                twe_i   = 1'b1;
            end else begin
                twe_i   = 1'b0;
            end
            @(negedge clk_i);
        end
        twe_i = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_tdin", tdin_o, 32'h0);
        chk("rst_pulse", {31'b0, step_pulse_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b0;

        // Sweep length, with a write dropped during CLEAR
        measure_busy(1'b1, busy_len);
        chk("sweep_len", busy_len, 256);

        // Whole RAM reads back zero after the sweep, 0x100 is unmapped
        taddr_i = 16'h0000;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk_i);
            chk($sformatf("clr_ram_%0d", i - 1), tdin_o, 32'h0);
            taddr_i = 16'(i);
        end
        @(negedge clk_i);
        chk("unmapped_100", tdin_o, BAD);
        rd(A_WCNT, 32'd0, "wcnt_after_clear_write");
        rd(A_LADR, 32'd0, "ladr_after_clear_write");
        rd(16'hFFFC, BAD, "unmapped_fffc");

        // RAM write with bypass and CSR side effects
        wr(16'h0012, 32'h1234_5678, 32'h1234_5678, "bypass_12");
        rd(16'h0012, 32'h1234_5678, "read_12");
        rd(16'h0013, 32'h0, "read_13");
        rd(A_WCNT, 32'd1, "wcnt_1");
        rd(A_LADR, 32'h0000_0012, "ladr_12");
        wr(16'h00FF, 32'hCAFE_F00D, 32'hCAFE_F00D, "bypass_ff");
        rd(16'h00FF, 32'hCAFE_F00D, "read_ff");
        rd(A_LADR, 32'h0000_00FF, "ladr_ff");

        // Writes to read-only CSRs and unmapped addresses are ignored
        wr(A_WCNT, 32'h0000_0055, 32'd2, "wr_wcnt_ignored");
        wr(A_LADR, 32'h0000_0077, 32'h0000_00FF, "wr_ladr_ignored");
        wr(16'h0200, 32'h1111_2222, BAD, "wr_unmapped_ignored");
        rd(A_WCNT, 32'd2, "wcnt_2");
        rd(16'h0012, 32'h1234_5678, "read_12_again");

        // Step pulses
        step_edge("step1");
        step_edge("step2");
        step_edge("step3");
        rd(A_STEP, 32'd3, "step_cnt_3");

        // Step counter wrap and write-beats-increment
        wr(A_STEP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "step_wr_max");
        step_edge("step_wrap");
        rd(A_STEP, 32'h0, "step_wrapped");
        taddr_i       = A_STEP;
        tdout_i       = 32'h0000_0010;
        twe_i         = 1'b1;
        step_stable_i = 1'b1;
        @(negedge clk_i);
        twe_i = 1'b0;
        chk("coinc_pulse", {31'b0, step_pulse_o}, 32'd1);
        chk("coinc_bypass", tdin_o, 32'h0000_0010);
        step_stable_i = 1'b0;
        @(negedge clk_i);
        rd(A_STEP, 32'h0000_0010, "step_write_wins");
        rd(A_WCNT, 32'd4, "wcnt_4");
        rd(A_LADR, 32'h0000_00FF, "ladr_kept");

        // Reset mid-sweep restarts the clear
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (100) @(negedge clk_i);
        chk("midsweep_busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rerst_busy", {31'b0, busy_o}, 32'd1);
        chk("rerst_tdin", tdin_o, 32'h0);
        rst_i = 1'b0;
        measure_busy(1'b0, busy_len);
        chk("resweep_len", busy_len, 256);
        rd(16'h0012, 32'h0, "recleared_12");
        rd(16'h00FF, 32'h0, "recleared_ff");
        rd(A_STEP, 32'h0, "rerst_step");
        rd(A_WCNT, 32'h0, "rerst_wcnt");
        rd(A_LADR, 32'h0, "rerst_ladr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
